// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: size-mask codes and the buffered store entry shared by the load/store paths
package store_buffer_pkg;
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam int ENTRY_AW = 32;
  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [3:0]          wen;
    logic [31:0]         wdata;
  } st_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: store request, memory write and status signals; STORE_FWD_EN adds the load-hazard probe
interface store_buffer_if #(parameter int ADDR_W = 32);
  logic              st_valid;
  logic              st_ready;
  logic [3:0]        st_memwrite;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_ades;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wen;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              empty;
`ifdef STORE_FWD_EN
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hazard;
`endif
  modport slave (
    input  st_valid, st_memwrite, st_addr, st_data, mem_ack,
    output st_ready, st_ades, mem_req, mem_addr, mem_wen, mem_wdata, empty
`ifdef STORE_FWD_EN
    , input ld_valid, ld_addr, output ld_hazard
`endif
  );
  modport master (
    output st_valid, st_memwrite, st_addr, st_data, mem_ack,
    input  st_ready, st_ades, mem_req, mem_addr, mem_wen, mem_wdata, empty
`ifdef STORE_FWD_EN
    , output ld_valid, ld_addr, input ld_hazard
`endif
  );
endinterface

// File: rtl/store_align.sv
// store_align: turns a size mask, byte offset and LSB-justified data into lane enables and replicated data
module store_align
  import store_buffer_pkg::*;
(
  input  logic [3:0]  memwrite,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  wen,
  output logic [31:0] wdata,
  output logic        mis,
  output logic        legal
);
  // lane placement and alignment check are pure functions of the request
  always_comb begin
    wen   = memwrite << offset;
    wdata = memwrite == MASK_BYTE ? {4{data[7:0]}} :
            memwrite == MASK_HALF ? {2{data[15:0]}} : data;
    mis   = (memwrite == MASK_HALF && offset[0]) || (memwrite == MASK_WORD && offset != 2'b00);
    legal = memwrite == MASK_BYTE || memwrite == MASK_HALF || memwrite == MASK_WORD;
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: aligns MEM-stage stores and drains them in order over req/ack; STORE_FWD_EN adds ld_hazard
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            resetn,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt;
  st_entry_t   buf_q [DEPTH];
  st_entry_t   buf_d [DEPTH];
  st_entry_t   new_e, head;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic        mis, legal, full, is_empty, enq, deq;

  store_align u_align (
    .memwrite(bus.st_memwrite),
    .offset  (bus.st_addr[1:0]),
    .data    (bus.st_data),
    .wen     (wen),
    .wdata   (wdata),
    .mis     (mis),
    .legal   (legal)
  );

  assign cnt           = wptr_q - rptr_q;
  assign full          = wptr_q[PW] != rptr_q[PW] && wptr_q[PW-1:0] == rptr_q[PW-1:0];
  assign is_empty      = wptr_q == rptr_q;
  assign enq           = bus.st_valid && !full && !mis && legal;
  assign deq           = !is_empty && bus.mem_ack;
  assign head          = buf_q[rptr_q[PW-1:0]];
  assign bus.st_ready  = !full;
  assign bus.st_ades   = bus.st_valid && mis;
  assign bus.empty     = is_empty;
  assign bus.mem_req   = !is_empty;
  assign bus.mem_addr  = head.addr[ADDR_W-1:0];
  assign bus.mem_wen   = head.wen;
  assign bus.mem_wdata = head.wdata;

  // write the aligned entry at the tail and advance whichever pointers handshook
  always_comb begin
    new_e.addr  = ENTRY_AW'({bus.st_addr[ADDR_W-1:2], 2'b00});
    new_e.wen   = wen;
    new_e.wdata = wdata;
    buf_d       = buf_q;
    if (enq) buf_d[wptr_q[PW-1:0]] = new_e;
    wptr_d = wptr_q + {{PW{1'b0}}, enq};
    rptr_d = rptr_q + {{PW{1'b0}}, deq};
  end

  // reset drops every pending store, including an un-acked head
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      buf_q  <= buf_d;
    end
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] idx;
  logic          haz;
  // a load hits if any occupied slot, head included, holds the same word
  always_comb begin
    haz = 1'b0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q[PW-1:0] + PW'(k);
      if ((PW+1)'(k) < cnt && buf_q[idx].addr[ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]) haz = 1'b1;
    end
  end
  assign bus.ld_hazard = bus.ld_valid && haz;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table plus hand sequences, checked against a scoreboard of expected memory writes
module tb_store_buffer;
  localparam int DEPTH = 2;
  typedef struct {
    logic [3:0]  mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ades;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } exp_t;

  logic clk, resetn;
  int   pass_cnt, total_cnt, cnt, cyc, last_acc_cyc, raise_cyc;
  logic acc, exp_ades, prev_hold;
  exp_t exp_e, prev_e, got_e;
  exp_t sb[$];
  vec_t vt[12];

  store_buffer_if #(.ADDR_W(32)) bus ();
  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  function automatic logic legal(input logic [3:0] m);
    return m == 4'b0001 || m == 4'b0011 || m == 4'b1111;
  endfunction

  // reference model: occupancy, handshake and the expected-write scoreboard
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_st_ready", bus.st_ready, 1);
      sb.delete();
      cnt = 0;
      acc = 0;
      prev_hold = 0;
    end else begin
      chk("st_ready", bus.st_ready, cnt < DEPTH);
      chk("mem_req", bus.mem_req, cnt != 0);
      chk("empty", bus.empty, cnt == 0);
      chk("st_ades", bus.st_ades, bus.st_valid & exp_ades);
      if (prev_hold) begin
        chk("hold_addr", bus.mem_addr, prev_e.addr);
        chk("hold_wen", bus.mem_wen, prev_e.wen);
        chk("hold_wdata", bus.mem_wdata, prev_e.wdata);
      end
      if (cnt != 0 && bus.mem_ack) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          got_e = sb.pop_front();
          chk("mem_addr", bus.mem_addr, got_e.addr);
          chk("mem_wen", bus.mem_wen, got_e.wen);
          chk("mem_wdata", bus.mem_wdata, got_e.wdata);
        end
      end
      acc = bus.st_valid && cnt < DEPTH;
      if (acc && !exp_ades && legal(bus.st_memwrite)) begin
        sb.push_back(exp_e);
        cnt++;
      end
      if (bus.mem_req && bus.mem_ack) cnt--;
      prev_hold = bus.mem_req && !bus.mem_ack;
      prev_e = '{bus.mem_addr, bus.mem_wen, bus.mem_wdata};
    end
  end

  task automatic drive_store(input vec_t v);
    bit got = 0;
    bus.st_valid = 1;
    bus.st_memwrite = v.mw;
    bus.st_addr = v.addr;
    bus.st_data = v.data;
    exp_ades = v.ades;
    exp_e = '{{v.addr[31:2], 2'b00}, v.wen, v.wdata};
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (acc) begin
        got = 1;
        last_acc_cyc = cyc;
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    bus.st_valid = 0;
    exp_ades = 0;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; cyc = 0; cnt = 0; acc = 0; prev_hold = 0;
    resetn = 0; exp_ades = 0; exp_e = '{0, 0, 0};
    bus.st_valid = 0; bus.st_memwrite = 0; bus.st_addr = 0; bus.st_data = 0; bus.mem_ack = 0;
`ifdef STORE_FWD_EN
    bus.ld_valid = 0; bus.ld_addr = 0;
`endif
    vt[0]  = '{4'b0001, 32'h1003, 32'h000000A5, 0, 4'b1000, 32'hA5A5A5A5};
    vt[1]  = '{4'b0011, 32'h2002, 32'h1234BEEF, 0, 4'b1100, 32'hBEEFBEEF};
    vt[2]  = '{4'b0011, 32'h2001, 32'h1234BEEF, 1, 4'b0000, 32'h0};
    vt[3]  = '{4'b1111, 32'h2002, 32'h1234BEEF, 1, 4'b0000, 32'h0};
    vt[4]  = '{4'b1111, 32'h4000, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF};
    vt[5]  = '{4'b0001, 32'h5000, 32'h12345678, 0, 4'b0001, 32'h78787878};
    vt[6]  = '{4'b0001, 32'h5001, 32'h12345678, 0, 4'b0010, 32'h78787878};
    vt[7]  = '{4'b0011, 32'h6000, 32'h0000CAFE, 0, 4'b0011, 32'hCAFECAFE};
    vt[8]  = '{4'b0000, 32'h7000, 32'h11111111, 0, 4'b0000, 32'h0};
    vt[9]  = '{4'b0111, 32'h7001, 32'h22222222, 0, 4'b0000, 32'h0};
    vt[10] = '{4'b1111, 32'h8004, 32'h11223344, 0, 4'b1111, 32'h11223344};
    vt[11] = '{4'b0001, 32'h9002, 32'h000000FF, 0, 4'b0100, 32'hFFFFFFFF};
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    bus.mem_ack = 1;

    drive_store(vt[0]);
    chk("lat_mem_req", bus.mem_req, 1);
    chk("lat_mem_addr", bus.mem_addr, 32'h1000);
    chk("lat_mem_wen", bus.mem_wen, 4'b1000);
    chk("lat_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("drained_empty", bus.empty, 1);

    for (int i = 1; i < 12; i++) drive_store(vt[i]);
    repeat (4) @(posedge clk); #1;
    chk("table_empty", bus.empty, 1);

    bus.mem_ack = 0;
    drive_store('{4'b1111, 32'hA000, 32'h11111111, 0, 4'b1111, 32'h11111111});
    drive_store('{4'b1111, 32'hA004, 32'h22222222, 0, 4'b1111, 32'h22222222});
    chk("bp_full_ready", bus.st_ready, 0);
    fork
      drive_store('{4'b1111, 32'hA008, 32'h33333333, 0, 4'b1111, 32'h33333333});
      begin
        repeat (3) @(posedge clk);
        #1 bus.mem_ack = 1;
        raise_cyc = cyc;
      end
    join
    chk("bp_accept_cycle", last_acc_cyc, raise_cyc + 2);
    repeat (4) @(posedge clk); #1;

    bus.mem_ack = 0;
    drive_store('{4'b0001, 32'hB000, 32'h00000011, 0, 4'b0001, 32'h11111111});
    drive_store('{4'b0001, 32'hB001, 32'h00000022, 0, 4'b0010, 32'h22222222});
    bus.mem_ack = 1;
    raise_cyc = cyc;
    drive_store('{4'b0001, 32'hB002, 32'h00000033, 0, 4'b0100, 32'h33333333});
    chk("full_enq_deq_cycle", last_acc_cyc, raise_cyc + 2);
    repeat (4) @(posedge clk); #1;

`ifdef STORE_FWD_EN
    bus.mem_ack = 0;
    drive_store('{4'b1111, 32'h3000, 32'h55555555, 0, 4'b1111, 32'h55555555});
    bus.ld_valid = 1; bus.ld_addr = 32'h3002;
    #1 chk("ld_hazard_hit", bus.ld_hazard, 1);
    bus.ld_addr = 32'h3004;
    #1 chk("ld_hazard_miss", bus.ld_hazard, 0);
    bus.ld_addr = 32'h3000; bus.ld_valid = 0;
    #1 chk("ld_hazard_novalid", bus.ld_hazard, 0);
    bus.mem_ack = 1;
    repeat (3) @(posedge clk); #1;
`endif

    bus.mem_ack = 0;
    drive_store('{4'b1111, 32'hC000, 32'h66666666, 0, 4'b1111, 32'h66666666});
    drive_store('{4'b1111, 32'hC004, 32'h77777777, 0, 4'b1111, 32'h77777777});
    resetn = 0;
    #1;
    chk("async_rst_req", bus.mem_req, 0);
    chk("async_rst_empty", bus.empty, 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    bus.mem_ack = 1;
    repeat (5) @(posedge clk); #1;
    chk("no_replay", bus.mem_req, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart of the load-path extractor. Takes store requests from the MEM stage and converts each one into a word-aligned memory write.
- For each store it produces a byte-lane write enable and lane-replicated write data.
- Queues stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Flags misaligned stores as address-error exceptions.

Parameters:
- DEPTH, 2, number of buffered stores; power of two, minimum 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept a request.
- st_memwrite  in  4  size mask: 0000 no store, 0001 sb, 0011 sh, 1111 sw.
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  unaligned store data, LSB-justified.
- st_ades  out  1  misaligned-store exception, combinational.
- mem_req  out  1  write request to data memory.
- mem_addr  out  ADDR_W  word address; bits [1:0] are always 0.
- mem_wen  out  4  byte write enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory accepts the current request.
- empty  out  1  no pending stores; used for fence/sync.

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low on resetn.
- On reset:
  - read and write pointers clear to 0 (log2(DEPTH)+1 bits each);
  - storage clears to 0;
  - mem_req=0, empty=1, st_ready=1.
  - Reset in the middle of a transaction discards all pending stores, including an un-acked head.
- Misalignment:
  - mis = (memwrite==0011 & addr[0]) | (memwrite==1111 & addr[1:0]!=0).
  - st_ades = st_valid & mis. It does not depend on st_ready.
  - A misaligned request is never enqueued.
- Accept:
  - accept = st_valid & st_ready.
  - enq = accept & ~mis & memwrite ∈ {0001, 0011, 1111}.
  - memwrite 0000 or any other code: handshake completes, nothing is enqueued, no exception.
- Alignment, computed at enqueue and stored in the entry:
  - wen = memwrite << addr[1:0];
  - wdata: sb {4{data[7:0]}}, sh {2{data[15:0]}}, sw data;
  - addr stored with [1:0] forced to 00.
- Ready and status:
  - st_ready = ~full. There is no same-cycle bypass: when full, no enqueue happens even if a dequeue occurs in that cycle.
  - full is true when pointer MSBs differ and the low bits are equal.
  - empty is true when the pointers are equal.
- Drain:
  - mem_req = ~empty. mem_addr, mem_wen and mem_wdata come from the head entry.
  - All request fields stay stable while mem_req=1 and mem_ack=0.
  - deq = mem_req & mem_ack. The read pointer advances on the next edge.
  - mem_ack while mem_req=0 is ignored.
- Timing:
  - Minimum latency from accept to mem_req is 1 cycle; the write is visible in the cycle after the accept edge.
  - Throughput is 1 store/cycle when mem_ack is held high.
- Simultaneous events:
  - enq and deq in the same cycle with the buffer not full: both take effect and occupancy is unchanged.
  - Pointers wrap naturally modulo 2*DEPTH.
- Ordering: stores drain strictly in FIFO order.

Optional Feature:
STORE_FWD_EN
- Defined:
  - adds input ld_valid (1), input ld_addr (ADDR_W) and output ld_hazard (1), all combinational.
  - ld_hazard = ld_valid & (some pending entry, head included, has addr[ADDR_W-1:2] equal to ld_addr[ADDR_W-1:2]).
  - An entry that is dequeued this cycle still counts as pending.
  - The pipeline stalls the load while ld_hazard=1.
- Undefined: the ports do not exist; software or the pipeline guarantees ordering.

Decomposition:
- Shared package (same package the load path uses):
  - memwrite/memtoreg size codes MASK_NONE=4'b0000, MASK_BYTE=4'b0001, MASK_HALF=4'b0011, MASK_WORD=4'b1111;
  - a store-entry struct {addr, wen, wdata}.
- Sub-module store_align (combinational): memwrite, offset, data -> wen, wdata, mis. Reusable by unbuffered paths.

Test Plan:
- Byte store, mem_ack held 1:
  - stimulus: sb addr 0x1003, data 0xA5.
  - response: next cycle mem_req=1, mem_addr=0x1000, mem_wen=1000, mem_wdata=0xA5A5A5A5; empty=1 after the ack edge.
- Halfword store:
  - stimulus: sh addr 0x2002, data 0x1234BEEF.
  - response: mem_wen=1100, mem_wdata=0xBEEFBEEF.
- Misaligned requests:
  - stimulus: sh addr 0x2001; sw addr 0x2002.
  - response: st_ades=1 in the same cycle for each; no mem_req follows; empty stays 1.
- Backpressure:
  - stimulus: mem_ack=0, three sw stores issued with DEPTH=2.
  - response: st_ready=0 after the second; mem_* fields stable throughout.
  - then raise mem_ack: stores drain in order, and the third is accepted in the cycle after the first ack.
- Full-cycle enq/deq:
  - stimulus: buffer full, mem_ack=1, st_valid=1.
  - response: no enqueue that cycle; the enqueue succeeds next cycle.
- Reset and forwarding:
  - stimulus: resetn low with two stores pending and the head un-acked.
  - response: mem_req drops immediately, empty=1, nothing is replayed after release.
  - STORE_FWD_EN: with an sw to 0x3000 pending, a load at 0x3002 gives ld_hazard=1 and a load at 0x3004 gives ld_hazard=0.
